// File: rtl/ped_signal_ctrl_if.sv
// ped_signal_ctrl_if: vehicle lamps and button in, pedestrian lamps out.
interface ped_signal_ctrl_if #(parameter int CNT_W = 8);
  logic red, yellow, green, ped_btn;
  logic walk, dont_walk, ped_wait, abort;
  logic [CNT_W-1:0] countdown;
  modport master(output red, yellow, green, ped_btn, input walk, dont_walk, ped_wait, countdown, abort);
  modport slave(input red, yellow, green, ped_btn, output walk, dont_walk, ped_wait, countdown, abort);
endinterface

// File: rtl/ped_signal_ctrl.sv
// ped_signal_ctrl: WALK/flash/hold pedestrian phasing keyed off the vehicle red lamp.
module ped_signal_ctrl #(
  parameter int WALK_CYC = 20,
  parameter int FLASH_CYC = 10,
  parameter int FLASH_HALF = 2,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  ped_signal_ctrl_if.slave p
);
  typedef enum logic [1:0] {IDLE, WALK, FLASH, HOLD} state_t;
  localparam logic [CNT_W-1:0] W_LD = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] F_LD = CNT_W'(FLASH_CYC);
  localparam logic [CNT_W-1:0] H_LD = CNT_W'(FLASH_HALF - 1);
  state_t state, state_n;
  logic req, req_n, btn_d, red_d, walk, walk_n, dw, dw_n, abort, abort_n;
  logic [CNT_W-1:0] cnt, cnt_n, hcnt, hcnt_n, cd, cd_n;
  logic safe_red, press, onset;
  assign safe_red = p.red & ~p.yellow & ~p.green;
  assign press = p.ped_btn & ~btn_d;
  assign onset = safe_red & ~red_d;
  always_comb begin
    state_n = state;
    req_n = req;
    cnt_n = cnt;
    hcnt_n = hcnt;
    walk_n = 1'b0;
    dw_n = 1'b1;
    cd_n = '0;
    abort_n = 1'b0;
    case (state)
      IDLE: begin
        req_n = req | press;
        if (onset && req_n) begin
          state_n = WALK;
          req_n = 1'b0;
          cnt_n = W_LD;
          walk_n = 1'b1;
          dw_n = 1'b0;
        end else if (onset) state_n = HOLD;
      end
      WALK: begin
        if (!safe_red) begin
          state_n = IDLE;
          req_n = 1'b1;
          abort_n = 1'b1;
        end else if (cnt == '0) begin
          state_n = FLASH;
          cd_n = F_LD;
          hcnt_n = H_LD;
        end else begin
          cnt_n = cnt - 1'b1;
          walk_n = 1'b1;
          dw_n = 1'b0;
        end
      end
      FLASH: begin
        req_n = req | press;
        if (!safe_red) begin
          state_n = IDLE;
          req_n = 1'b1;
          abort_n = 1'b1;
        end else if (cd == CNT_W'(1)) state_n = HOLD;
        else begin
          cd_n = cd - 1'b1;
          dw_n = (hcnt == '0) ? ~dw : dw;
          hcnt_n = (hcnt == '0) ? H_LD : hcnt - 1'b1;
        end
      end
      default: begin
        req_n = req | press;
        state_n = safe_red ? HOLD : IDLE;
      end
    endcase
  end
  // red_d resets high so a red already lit at reset release is not an onset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req <= 1'b0;
      btn_d <= 1'b0;
      red_d <= 1'b1;
      cnt <= '0;
      hcnt <= '0;
      cd <= '0;
      walk <= 1'b0;
      dw <= 1'b1;
      abort <= 1'b0;
    end else begin
      state <= state_n;
      req <= req_n;
      btn_d <= p.ped_btn;
      red_d <= safe_red;
      cnt <= cnt_n;
      hcnt <= hcnt_n;
      cd <= cd_n;
      walk <= walk_n;
      dw <= dw_n;
      abort <= abort_n;
    end
  end
  assign p.walk = walk;
  assign p.dont_walk = dw;
  assign p.ped_wait = req;
  assign p.countdown = cd;
  assign p.abort = abort;
endmodule

// File: tb/tb_ped_signal_ctrl.sv
// tb_ped_signal_ctrl: directed plan plus random lamp traffic, scoreboarded against a phase/elapsed-time model.
module tb_ped_signal_ctrl;
  localparam int WC = 4, FC = 6, FH = 2, CW = 8;
  localparam int M_IDLE = 0, M_WALK = 1, M_FLASH = 2, M_HOLD = 3;
  typedef struct packed {logic walk, dw, wt, ab; logic [CW-1:0] cd;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  ped_signal_ctrl_if #(.CNT_W(CW)) pif();
  ped_signal_ctrl #(.WALK_CYC(WC), .FLASH_CYC(FC), .FLASH_HALF(FH), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .p(pif));
  exp_t q[$];
  int total = 0, bad = 0;
  int mode = M_IDLE, t = 0;
  bit req = 0, pb = 0, pr = 1;
  task automatic step(input bit rs, input bit r, input bit y, input bit g, input bit b);
    bit sr, press, on, ab;
    exp_t e;
    rst = rs; pif.red = r; pif.yellow = y; pif.green = g; pif.ped_btn = b;
    @(posedge clk);
    ab = 0;
    if (rs) begin
      mode = M_IDLE; t = 0; req = 0; pb = 0; pr = 1;
    end else begin
      sr = r && !y && !g;
      press = b && !pb;
      on = sr && !pr;
      if (mode != M_WALK && press) req = 1;
      if (mode == M_IDLE) begin
        if (on && req) begin mode = M_WALK; t = 0; req = 0; end
        else if (on) mode = M_HOLD;
      end else if (mode == M_HOLD) begin
        if (!sr) mode = M_IDLE;
      end else if (!sr) begin
        mode = M_IDLE; req = 1; ab = 1;
      end else begin
        t++;
        if (mode == M_WALK && t == WC) begin mode = M_FLASH; t = 0; end
        else if (mode == M_FLASH && t == FC) begin mode = M_HOLD; t = 0; end
      end
      pb = b; pr = sr;
    end
    e.walk = (mode == M_WALK);
    e.dw = (mode != M_WALK) && !(mode == M_FLASH && ((t / FH) % 2 == 1));
    e.wt = req;
    e.ab = ab;
    e.cd = (mode == M_FLASH) ? CW'(FC - t) : '0;
    q.push_back(e);
    #1;
  endtask
  task automatic lamps(input int n, input bit r, input bit y, input bit g);
    for (int i = 0; i < n; i++) step(0, r, y, g, 0);
  endtask
  always @(negedge clk) begin
    exp_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {pif.walk, pif.dont_walk, pif.ped_wait, pif.abort, pif.countdown};
      total++;
      if (a !== e)
        begin bad++; $display("FAIL outputs @%0t got walk=%b dw=%b wait=%b abort=%b cd=%0d want walk=%b dw=%b wait=%b abort=%b cd=%0d",
          $time, a.walk, a.dw, a.wt, a.ab, a.cd, e.walk, e.dw, e.wt, e.ab, e.cd); end
      total++;
      if (pif.walk && pif.dont_walk) begin bad++; $display("FAIL exclusive @%0t got walk=1 dw=1 want not both", $time); end
    end
  end
  initial begin
    int ph, len;
    bit r, y, g;
    step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
    lamps(10, 1, 0, 0);
    lamps(3, 0, 0, 1); step(0, 0, 0, 1, 1); lamps(3, 0, 0, 1); lamps(2, 0, 1, 0);
    lamps(16, 1, 0, 0); lamps(3, 0, 0, 1);
    lamps(2, 0, 1, 0); lamps(3, 1, 0, 0); step(0, 1, 0, 0, 1); lamps(3, 1, 0, 0);
    lamps(5, 0, 0, 1); lamps(1, 0, 1, 0); lamps(15, 1, 0, 0);
    lamps(2, 0, 0, 1); step(0, 0, 0, 1, 1); lamps(2, 0, 0, 1);
    lamps(1, 1, 0, 0); lamps(1, 0, 0, 1); lamps(3, 0, 0, 1); lamps(6, 1, 0, 0);
    lamps(2, 0, 0, 1); step(0, 0, 0, 1, 1); lamps(1, 0, 0, 1);
    lamps(4, 1, 1, 0); lamps(12, 1, 0, 0); lamps(3, 0, 0, 1);
    step(0, 0, 0, 1, 1); lamps(2, 0, 0, 1); lamps(8, 1, 0, 0);
    step(0, 1, 0, 0, 1); step(1, 1, 0, 0, 1); step(1, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 1);
    lamps(3, 0, 0, 1); lamps(14, 1, 0, 0);
    ph = 0;
    repeat (60) begin
      len = (ph == 2) ? $urandom_range(3, 16) : $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        {r, y, g} = (ph == 2) ? 3'b100 : (ph == 1) ? 3'b010 : 3'b001;
        if ($urandom_range(0, 19) == 0) {r, y, g} = 3'($urandom_range(0, 7));
        step($urandom_range(0, 149) == 0, r, y, g, $urandom_range(0, 5) == 0);
      end
      ph = (ph + 1) % 3;
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL drain got %0d pending want 0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
